prescaler_ctrl: RTL

//  Sequencer for the clock-divide path. Holds a shadow divide value written by the register

---
 rtl/prescaler_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/prescaler_ctrl.sv
// Divide-path sequencer: shadowed divide value applied on period wrap, tick/phase/done.
// Optional one-shot tick counting is enabled by defining PSC_ONESHOT_EN.
module prescaler_ctrl #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_wr,
  input  logic [DW-1:0] cfg_div,
  input  logic [CW-1:0] cfg_cnt,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          cfg_pend,
  output logic [DW-1:0] div_active,
  output logic          tick,
  output logic          phase,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] sdiv_q, sdiv_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] num_q, num_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          phase_q, phase_d;
  logic          done_q, done_d;
  logic          wrap;
  logic          last;

  assign wrap = (count_q == div_q);

`ifdef PSC_ONESHOT_EN
  assign last = (cnt_q != '0) && (CW'(num_q + 1'b1) == cnt_q);
`else
  logic unused_cnt;
  assign last       = 1'b0;
  assign unused_cnt = ^cnt_q;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sdiv_d  = sdiv_q;
    div_d   = div_q;
    scnt_d  = scnt_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    pend_d  = pend_q;
    tick_d  = 1'b0;
    phase_d = phase_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          div_d   = sdiv_q;
          cnt_d   = scnt_q;
          pend_d  = 1'b0;
          count_d = '0;
          num_d   = '0;
          phase_d = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
          num_d   = '0;
          phase_d = 1'b0;
        end else if (wrap) begin
          // period boundary: the only point where a new divide may take effect
          count_d = '0;
          tick_d  = 1'b1;
          phase_d = ~phase_q;
          div_d   = sdiv_q;
          pend_d  = 1'b0;
          if (last) begin
            done_d  = 1'b1;
            state_d = FIN;
            num_d   = '0;
          end else begin
            num_d = num_q + 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        count_d = '0;
        num_d   = '0;
        phase_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (cfg_wr) begin
      sdiv_d = cfg_div;
      scnt_d = cfg_cnt;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sdiv_q  <= '0;
      div_q   <= '0;
      scnt_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      pend_q  <= 1'b0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sdiv_q  <= sdiv_d;
      div_q   <= div_d;
      scnt_q  <= scnt_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign cfg_pend   = pend_q;
  assign div_active = div_q;
  assign tick       = tick_q;
  assign phase      = phase_q;
  assign done       = done_q;

endmodule
